// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART string-transmit arbiter.
// State encoding, default string geometry and the length clamp.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } arb_state_e;

    localparam int STR_W_DEF = 1024;
    localparam int STR_BYTES = STR_W_DEF / 8;

    // Limit a requested byte count to what the string register can hold.
    function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] max_bytes);
        return (len > max_bytes) ? max_bytes : len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
// Produces a one-hot grant, an any flag and the winner index.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [2:0]         ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               any_o,
    output logic [2:0]         idx_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // cand[k] is the requester examined at search step k (ptr+1+k mod NUM_REQ).
    logic [IDX_W-1:0] cand [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((int'(ptr_i) + gi + 1) % NUM_REQ);
        end
    endgenerate

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_o && req_i[cand[k]]) begin
                any_o            = 1'b1;
                grant_o[cand[k]] = 1'b1;
                idx_o            = 3'(cand[k]);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_string_handle transmit channel among
// NUM_REQ requesters, with a WAIT watchdog and sticky timeout flag.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int STR_W       = 1024,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*STR_W-1:0]   req_string,
    input  logic [NUM_REQ*LEN_W-1:0]   req_length,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       req_err,
    output logic [STR_W-1:0]           tx_string,
    output logic [LEN_W-1:0]           tx_length,
    output logic                       tx_req,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [2:0]                 grant_id,
    output logic                       arb_busy,
    output logic                       err_timeout,
    input  logic                       err_clr
);
    localparam int NBYTES = STR_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e state_q, state_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic [STR_W-1:0]   tx_string_q, tx_string_d;
    logic [LEN_W-1:0]   tx_length_q, tx_length_d;
    logic               tx_req_q, tx_req_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0] req_done_q, req_done_d;
    logic               req_err_q, req_err_d;
    logic               err_timeout_q, err_timeout_d;
    logic               abort_q, abort_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [STR_W-1:0]   str_arr [NUM_REQ];
    logic [LEN_W-1:0]   len_arr [NUM_REQ];
    logic [NUM_REQ-1:0] win_oh;
    logic               win_any;
    logic [2:0]         win_idx;
    logic [STR_W-1:0]   sel_str;
    logic [LEN_W-1:0]   sel_len;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign str_arr[gi] = req_string[gi*STR_W +: STR_W];
            assign len_arr[gi] = req_length[gi*LEN_W +: LEN_W];
        end
    endgenerate

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (win_oh),
        .any_o   (win_any),
        .idx_o   (win_idx)
    );

    always_comb begin
        sel_str = '0;
        sel_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                sel_str = str_arr[i];
                sel_len = len_arr[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        tx_string_d   = tx_string_q;
        tx_length_d   = tx_length_q;
        cnt_d         = cnt_q;
        abort_d       = abort_q;
        tx_req_d      = 1'b0;
        req_ack_d     = '0;
        req_done_d    = '0;
        req_err_d     = 1'b0;
        // A timeout raised this cycle overrides a simultaneous clear below.
        err_timeout_d = err_timeout_q & ~err_clr;

        unique case (state_q)
            IDLE: begin
                if (win_any && !tx_busy) begin
                    req_ack_d   = win_oh;
                    grant_id_d  = win_idx;
                    tx_string_d = sel_str;
                    tx_length_d = LEN_W'(clamp_len(32'(sel_len), 32'(NBYTES)));
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (tx_length_q == '0) begin
                    state_d = DONE;
                end else begin
                    tx_req_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_timeout_d = 1'b1;
                    abort_d       = 1'b1;
                    state_d       = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (!tx_busy) state_d = DONE;
            end
            DONE: begin
                rr_ptr_d = grant_id_q;
                cnt_d    = '0;
                abort_d  = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Completion is registered on entry so req_done is high exactly during DONE.
        if (state_d == DONE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_done_d[i] = (grant_id_d == 3'(i));
            end
            req_err_d = abort_d;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 3'(NUM_REQ - 1);
            grant_id_q    <= '0;
            tx_string_q   <= '0;
            tx_length_q   <= '0;
            tx_req_q      <= 1'b0;
            req_ack_q     <= '0;
            req_done_q    <= '0;
            req_err_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            abort_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            tx_string_q   <= tx_string_d;
            tx_length_q   <= tx_length_d;
            tx_req_q      <= tx_req_d;
            req_ack_q     <= req_ack_d;
            req_done_q    <= req_done_d;
            req_err_q     <= req_err_d;
            err_timeout_q <= err_timeout_d;
            abort_q       <= abort_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign req_done    = req_done_q;
    assign req_err     = req_err_q;
    assign tx_string   = tx_string_q;
    assign tx_length   = tx_length_q;
    assign tx_req      = tx_req_q;
    assign grant_id    = grant_id_q;
    assign arb_busy    = (state_q != IDLE);
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_string_handle model.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int SW   = 1024;
    localparam int LW   = 8;
    localparam int TO   = 600;

    logic                 sys_clk, sys_rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SW-1:0]   req_string;
    logic [NREQ*LW-1:0]   req_length;
    logic [NREQ-1:0]      req_ack, req_done;
    logic                 req_err;
    logic [SW-1:0]        tx_string;
    logic [LW-1:0]        tx_length;
    logic                 tx_req, tx_busy, tx_done;
    logic [2:0]           grant_id;
    logic                 arb_busy, err_timeout, err_clr;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .STR_W(SW), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_string(req_string), .req_length(req_length),
        .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
        .tx_string(tx_string), .tx_length(tx_length), .tx_req(tx_req),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id),
        .arb_busy(arb_busy), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        int          id;
        int          len;
        bit          do_tx;
        bit          err;
        logic [63:0] str_lo;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    bit          active;
    int          n_chk, n_err, n_done, cyc;
    int          ack_cyc, txreq_cyc, txdone_cyc, busyfall_cyc, txcnt;
    int          req_cnt [NREQ];
    int          req_len [NREQ];
    logic [63:0] req_lo  [NREQ];
    int          model_delay, m_cnt;
    bit          model_hang, prev_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [63:0] onehot(input int id);
        return 64'(1) << id;
    endfunction

    task automatic load_req(input int id, input int len, input logic [63:0] lo, input int count);
        logic [SW-1:0] s;
        for (int w = 0; w < SW/32; w++) s[w*32 +: 32] = $urandom();
        s[63:0] = lo;
        req_string[id*SW +: SW] = s;
        req_length[id*LW +: LW] = LW'(len);
        req_len[id] = len;
        req_lo[id]  = lo;
        req_cnt[id] = count;
    endtask

    task automatic push_exp(input int id, input bit err);
        exp_t e;
        e.id     = id;
        e.len    = (req_len[id] > SW/8) ? SW/8 : req_len[id];
        e.do_tx  = (e.len != 0);
        e.err    = err;
        e.str_lo = req_lo[id];
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        if (req_ack != '0) begin
            if (exp_q.size() == 0 || active) begin
                check("unexpected_ack", 64'(req_ack), 64'(0));
            end else begin
                cur = exp_q.pop_front();
                check("ack_id", 64'(req_ack), onehot(cur.id));
                check("grant_id", 64'(grant_id), 64'(cur.id));
                active  = 1'b1;
                txcnt   = 0;
                ack_cyc = cyc;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i]) begin
                    req_cnt[i]--;
                    if (req_cnt[i] <= 0) req_valid[i] = 1'b0;
                end
            end
        end
        if (tx_req) begin
            if (!active) begin
                check("unexpected_tx_req", 64'(1), 64'(0));
            end else begin
                check("tx_busy_at_req", 64'(tx_busy), 64'(0));
                check("tx_length", 64'(tx_length), 64'(cur.len));
                check("tx_string_lo", tx_string[63:0], cur.str_lo);
                txcnt++;
                txreq_cyc = cyc;
            end
        end
        if (err_timeout && !prev_err) begin
            if (active) check("timeout_latency", 64'(cyc - txreq_cyc), 64'(TO));
            else        check("unexpected_timeout", 64'(1), 64'(0));
        end
        prev_err = err_timeout;
        if (req_done != '0) begin
            if (!active) begin
                check("unexpected_done", 64'(req_done), 64'(0));
            end else begin
                check("done_id", 64'(req_done), onehot(cur.id));
                check("done_err", 64'(req_err), 64'(cur.err));
                check("tx_req_count", 64'(txcnt), 64'(cur.do_tx));
                if (cur.do_tx) check("tx_length_stable", 64'(tx_length), 64'(cur.len));
                if (!cur.do_tx)     check("zero_len_latency", 64'(cyc - ack_cyc), 64'(1));
                else if (cur.err)   check("drain_latency", 64'(cyc - busyfall_cyc), 64'(1));
                else                check("done_latency", 64'(cyc - txdone_cyc), 64'(1));
                $display("txn: req%0d len=%0d err=%0b done at cycle %0d", cur.id, cur.len, req_err, cyc);
                active = 1'b0;
                n_done++;
            end
        end
    endtask

    // Behavioural uart_string_handle: busy for model_delay cycles after tx_req.
    task automatic model();
        if (tx_done) tx_done = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                tx_busy      = 1'b0;
                busyfall_cyc = cyc;
                if (!model_hang) begin
                    tx_done    = 1'b1;
                    txdone_cyc = cyc;
                end
            end
        end
        if (tx_req && !sys_rst) begin
            tx_busy = 1'b1;
            m_cnt   = model_delay;
        end
    endtask

    initial begin
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (!sys_rst) monitor();
            model();
        end
    end

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        check("done_count", 64'(n_done), 64'(target));
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        active  = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        int k;
        sys_rst = 1'b1; req_valid = '0; req_string = '0; req_length = '0;
        tx_busy = 1'b0; tx_done = 1'b0; err_clr = 1'b0;
        model_delay = 20; model_hang = 1'b0; m_cnt = 0;
        n_chk = 0; n_err = 0; n_done = 0; cyc = 0; active = 1'b0; prev_err = 1'b0;
        for (int i = 0; i < NREQ; i++) req_cnt[i] = 0;
        repeat (3) @(negedge sys_clk);
        check("rst_req_ack", 64'(req_ack), 64'(0));
        check("rst_req_done", 64'(req_done), 64'(0));
        check("rst_tx_req", 64'(tx_req), 64'(0));
        check("rst_tx_length", 64'(tx_length), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        check("rst_arb_busy", 64'(arb_busy), 64'(0));
        check("rst_err_timeout", 64'(err_timeout), 64'(0));
        sys_rst = 1'b0;

        // single requester, "hello" (byte 0 = 'h'), 500-cycle transfer
        @(negedge sys_clk);
        load_req(0, 5, 64'h0000_006f_6c6c_6568, 1);
        push_exp(0, 1'b0);
        model_delay = 500;
        req_valid[0] = 1'b1;
        @(negedge sys_clk);
        check("t1_ack_latency", 64'(req_ack), 64'(1));
        wait_done(1, 1000);

        // all four at once after reset: order 0,1,2,3,0
        do_reset();
        model_delay = 20;
        load_req(0, 3, 64'h1111_2222_3333_4444, 2);
        load_req(1, 4, 64'h5555_6666_7777_8888, 1);
        load_req(2, 6, 64'h9999_aaaa_bbbb_cccc, 1);
        load_req(3, 7, 64'hdddd_eeee_ffff_0123, 1);
        push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(2, 1'b0);
        push_exp(3, 1'b0); push_exp(0, 1'b0);
        req_valid = '1;
        wait_done(6, 1000);

        // zero length: ack then done without tx_req
        load_req(2, 0, 64'h0bad_0bad_0bad_0bad, 1);
        push_exp(2, 1'b0);
        req_valid[2] = 1'b1;
        wait_done(7, 50);

        // over-long length clamps to the string size
        load_req(1, 200, 64'hfeed_face_cafe_beef, 1);
        push_exp(1, 1'b0);
        req_valid[1] = 1'b1;
        wait_done(8, 200);
        check("t4_clamped_len", 64'(tx_length), 64'(STR_BYTES));

        // watchdog: busy held with no tx_done
        model_hang  = 1'b1;
        model_delay = TO + 200;
        load_req(1, 9, 64'h0123_4567_89ab_cdef, 1);
        push_exp(1, 1'b1);
        req_valid[1] = 1'b1;
        k = 0;
        while (!err_timeout && k < TO + 100) begin
            @(negedge sys_clk);
            k++;
        end
        check("t5_timeout_seen", 64'(err_timeout), 64'(1));
        @(negedge sys_clk);
        check("t5_in_drain", 64'(arb_busy), 64'(1));
        check("t5_no_early_done", 64'(req_done), 64'(0));
        wait_done(9, 400);
        check("t5_err_sticky", 64'(err_timeout), 64'(1));
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        check("t5_err_cleared", 64'(err_timeout), 64'(0));
        model_hang = 1'b0;

        // reset during WAIT with req3 pending
        model_delay = 300;
        load_req(0, 4, 64'h7777_0000_7777_0000, 1);
        push_exp(0, 1'b0);
        req_valid[0] = 1'b1;
        k = 0;
        while (!(active && txcnt == 1) && k < 50) begin
            @(negedge sys_clk);
            k++;
        end
        check("t6_in_wait", 64'(txcnt), 64'(1));
        repeat (50) @(negedge sys_clk);
        load_req(3, 8, 64'h3333_3333_3333_3333, 1);
        push_exp(3, 1'b0);
        req_valid[3] = 1'b1;
        #2;
        sys_rst = 1'b1;
        active  = 1'b0;
        #1;
        check("t6_rst_arb_busy", 64'(arb_busy), 64'(0));
        check("t6_rst_grant_id", 64'(grant_id), 64'(0));
        check("t6_rst_tx_length", 64'(tx_length), 64'(0));
        check("t6_rst_tx_string", tx_string[63:0], 64'(0));
        check("t6_rst_tx_req", 64'(tx_req), 64'(0));
        check("t6_rst_req_ack", 64'(req_ack), 64'(0));
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        model_delay = 10;
        k = 0;
        while (!active && k < 400) begin
            @(negedge sys_clk);
            k++;
        end
        check("t6_req3_granted", 64'(active), 64'(1));
        check("t6_grant_after_busy", 64'(ack_cyc - busyfall_cyc), 64'(1));
        wait_done(n_done + 1, 100);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        repeat (5) @(negedge sys_clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
